// File: rtl/clock_ctrl_pkg.sv
// Shared constants, types and BCD helper for the Basys3 HH:MM clock controller.
package clock_ctrl_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Encoding 2'd3 is left unnamed on purpose; the FSM maps it back to RUN.
    typedef enum logic [1:0] {
        ST_RUN     = MODE_RUN,
        ST_SET_HR  = MODE_SET_HR,
        ST_SET_MIN = MODE_SET_MIN
    } state_e;

    // Two-digit BCD increment {tens,units}; wraps to 00 after 'last' (e.g. 8'h59, 8'h23).
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] last);
        logic [7:0] r;
        if (v == last)
            r = 8'h00;
        else if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10..15 render blank.
import clock_ctrl_pkg::*;

module seg7_decode (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup, {g,f,e,d,c,b,a}, a segment is lit when its bit is 0
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = 7'b1000000;
            4'd1: seg_o = 7'b1111001;
            4'd2: seg_o = 7'b0100100;
            4'd3: seg_o = 7'b0110000;
            4'd4: seg_o = 7'b0011001;
            4'd5: seg_o = 7'b0010010;
            4'd6: seg_o = 7'b0000010;
            4'd7: seg_o = 7'b1111000;
            4'd8: seg_o = 7'b0000000;
            4'd9: seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Basys3 24 h HH:MM clock: button sync/edge detect, 1 Hz prescaler, RUN/SET FSM,
// BCD timekeeping and a registered 4-digit multiplexed seven-segment driver.
// Everything runs on clk with clock enables; no derived clocks.
import clock_ctrl_pkg::*;

module clock_time_ctrl #(
    parameter int SEC_DIV  = 100_000_000,
    parameter int SCAN_DIV = 25_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        sec_led,
    output logic [1:0]  mode,
    output logic [15:0] time_bcd
);

    localparam int PW = $clog2(SEC_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SEC_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(SEC_DIV / 2);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    // Button synchronisers: [0] first flop, [1] second flop, prev = delayed [1]
    logic [1:0] mode_s_q, inc_s_q;
    logic       mode_prev_q, inc_prev_q;
    logic       mode_pulse, inc_pulse, inc_act;

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        hr_q, hr_d, mn_q, mn_d, ss_q, ss_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              sec_tick, phase, enter_hr, blank;
    logic [3:0]        digit;
    logic [6:0]        seg_raw;

    // Two-flop synchronisers plus one-cycle rising-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s_q    <= 2'b00;
            inc_s_q     <= 2'b00;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            mode_s_q    <= {mode_s_q[0], btn_mode};
            inc_s_q     <= {inc_s_q[0], btn_inc};
            mode_prev_q <= mode_s_q[1];
            inc_prev_q  <= inc_s_q[1];
        end
    end

    assign mode_pulse = mode_s_q[1] & ~mode_prev_q;
    assign inc_pulse  = inc_s_q[1] & ~inc_prev_q;
    // A simultaneous mode press swallows the increment
    assign inc_act    = inc_pulse & ~mode_pulse;

    assign sec_tick = (presc_q == PRESC_LAST);
    assign phase    = (presc_q >= PRESC_HALF);
    assign enter_hr = (state_q == ST_RUN) && mode_pulse;

    // Mode FSM next state; the unused encoding falls back to RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (mode_pulse) state_d = ST_SET_HR;
            ST_SET_HR:  if (mode_pulse) state_d = ST_SET_MIN;
            ST_SET_MIN: if (mode_pulse) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Prescaler, time registers and scan position next-state
    always_comb begin
        presc_d = sec_tick ? '0 : presc_q + PW'(1);
        hr_d    = hr_q;
        mn_d    = mn_q;
        ss_d    = ss_q;

        if ((state_q == ST_RUN) && sec_tick) begin
            ss_d = bcd_inc_wrap(ss_q, 8'h59);
            if (ss_q == 8'h59) begin
                mn_d = bcd_inc_wrap(mn_q, 8'h59);
                if (mn_q == 8'h59)
                    hr_d = bcd_inc_wrap(hr_q, 8'h23);
            end
        end

        if (inc_act) begin
            if (state_q == ST_SET_HR)
                hr_d = bcd_inc_wrap(hr_q, 8'h23);
            else if (state_q == ST_SET_MIN)
                mn_d = bcd_inc_wrap(mn_q, 8'h59);
        end

        // Setting starts from a clean second boundary
        if (enter_hr) begin
            ss_d    = 8'h00;
            presc_d = '0;
        end

        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
        idx_d  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    end

    // Digit select: idx0..3 = mn_u, mn_t, hr_u, hr_t
    always_comb begin
        digit = 4'd0;
        case (idx_q)
            2'd0: digit = mn_q[3:0];
            2'd1: digit = mn_q[7:4];
            2'd2: digit = hr_q[3:0];
            2'd3: digit = hr_q[7:4];
            default: digit = 4'd0;
        endcase
    end

    seg7_decode u_dec (
        .bcd_i (digit),
        .seg_o (seg_raw)
    );

    // Display drive: blink the field being set, colon on digit 2 during even seconds
    always_comb begin
        blank = phase && (((state_q == ST_SET_HR)  &&  idx_q[1]) ||
                          ((state_q == ST_SET_MIN) && !idx_q[1]));
        an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : seg_raw;
        dp_d  = !((idx_q == 2'd2) && (state_q == ST_RUN) && !ss_q[0]);
    end

    // All state registers, including the display outputs, share one sync reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            scan_q  <= '0;
            idx_q   <= 2'd0;
            hr_q    <= 8'h00;
            mn_q    <= 8'h00;
            ss_q    <= 8'h00;
            an_q    <= 4'b1110;
            seg_q   <= SEG_ZERO;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            hr_q    <= hr_d;
            mn_q    <= mn_d;
            ss_q    <= ss_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign sec_led  = ss_q[0];
    assign mode     = state_q;
    assign time_bcd = {hr_q, mn_q};

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with SEC_DIV=10, SCAN_DIV=4.
module tb_clock_time_ctrl;

    logic        clk, rst, btn_mode, btn_inc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, sec_led;
    logic [1:0]  mode;
    logic [15:0] time_bcd;

    int n_cmp = 0;
    int n_bad = 0;

    clock_time_ctrl #(.SEC_DIV(10), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .sec_led  (sec_led),
        .mode     (mode),
        .time_bcd (time_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // chk bits: [3]=an [2]=seg [1]=dp [0]=sec_led; mode and time always checked
    typedef struct {
        logic        rst;
        int          n;
        logic [3:0]  chk;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        sl;
        logic [1:0]  mode;
        logic [15:0] tm;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic r, int n, logic [3:0] c, logic [3:0] a,
                                logic [6:0] s, logic d, logic l, logic [15:0] t);
        vec_t v;
        v.rst = r; v.n = n; v.chk = c; v.an = a; v.seg = s;
        v.dp = d; v.sl = l; v.mode = 2'd0; v.tm = t;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One press: hold for 4 clk (action lands on the 3rd edge), release for 4 clk
    task automatic press(input bit is_mode);
        if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
        step(4);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(4);
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (an === v) begin ok = 1'b1; break; end
            step(1);
        end
        chk(nm, {15'd0, ok}, 16'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int  nblank, nlow, nsegbad;
        bit  changed;

        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;

        // Reset, scan walk, colon and seconds LED; cycle counts are after reset release
        vecs[0]  = mk(1'b1,   2, 4'b1111, 4'b1110, 7'h40, 1'b1, 1'b0, 16'h0000);
        vecs[1]  = mk(1'b0,   4, 4'b1000, 4'b1110, 7'h40, 1'b1, 1'b0, 16'h0000);
        vecs[2]  = mk(1'b0,   1, 4'b1010, 4'b1101, 7'h40, 1'b1, 1'b0, 16'h0000);
        vecs[3]  = mk(1'b0,   4, 4'b1111, 4'b1011, 7'h40, 1'b0, 1'b0, 16'h0000);
        vecs[4]  = mk(1'b0,   1, 4'b0001, 4'b0000, 7'h40, 1'b1, 1'b1, 16'h0000);
        vecs[5]  = mk(1'b0,   1, 4'b1010, 4'b1011, 7'h40, 1'b1, 1'b1, 16'h0000);
        vecs[6]  = mk(1'b0,   2, 4'b1010, 4'b0111, 7'h40, 1'b1, 1'b1, 16'h0000);
        vecs[7]  = mk(1'b0,   7, 4'b0001, 4'b0000, 7'h40, 1'b1, 1'b0, 16'h0000);
        vecs[8]  = mk(1'b0,   6, 4'b1010, 4'b1011, 7'h40, 1'b0, 1'b0, 16'h0000);
        vecs[9]  = mk(1'b0, 573, 4'b0001, 4'b0000, 7'h40, 1'b1, 1'b1, 16'h0000);
        vecs[10] = mk(1'b0,   1, 4'b0001, 4'b0000, 7'h40, 1'b1, 1'b0, 16'h0001);

        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst;
            step(vecs[i].n);
            if (vecs[i].chk[3]) chk($sformatf("v%0d_an", i),  {12'd0, an},  {12'd0, vecs[i].an});
            if (vecs[i].chk[2]) chk($sformatf("v%0d_seg", i), {9'd0, seg},  {9'd0, vecs[i].seg});
            if (vecs[i].chk[1]) chk($sformatf("v%0d_dp", i),  {15'd0, dp},  {15'd0, vecs[i].dp});
            if (vecs[i].chk[0]) chk($sformatf("v%0d_sl", i),  {15'd0, sec_led}, {15'd0, vecs[i].sl});
            chk($sformatf("v%0d_mode", i), {14'd0, mode}, {14'd0, vecs[i].mode});
            chk($sformatf("v%0d_time", i), time_bcd, vecs[i].tm);
        end

        // Set 23:59 and watch the midnight rollover
        do_reset();
        press(1'b1);
        chk("t3_mode_hr", {14'd0, mode}, 16'd1);
        for (int i = 0; i < 23; i++) press(1'b0);
        chk("t3_hr23", time_bcd, 16'h2300);
        press(1'b1);
        chk("t3_mode_min", {14'd0, mode}, 16'd2);
        for (int i = 0; i < 59; i++) press(1'b0);
        chk("t3_mn59", time_bcd, 16'h2359);
        press(1'b1);
        chk("t3_mode_run", {14'd0, mode}, 16'd0);
        wait_an(4'b1110, "t3_wait_d0");
        chk("t3_seg_d0", {9'd0, seg}, {9'd0, 7'b0010000});
        wait_an(4'b1101, "t3_wait_d1");
        chk("t3_seg_d1", {9'd0, seg}, {9'd0, 7'b0010010});
        wait_an(4'b1011, "t3_wait_d2");
        chk("t3_seg_d2", {9'd0, seg}, {9'd0, 7'b0110000});
        wait_an(4'b0111, "t3_wait_d3");
        chk("t3_seg_d3", {9'd0, seg}, {9'd0, 7'b0100100});
        changed = 1'b0;
        for (int i = 0; i < 700; i++) begin
            step(1);
            if (time_bcd !== 16'h2359) begin changed = 1'b1; break; end
        end
        chk("t3_rolled", {15'd0, changed}, 16'd1);
        chk("t3_midnight", time_bcd, 16'h0000);

        // SET_HR: hour wrap, blinking of the hour digits, time frozen
        press(1'b1);
        chk("t4_mode_hr", {14'd0, mode}, 16'd1);
        press(1'b0);
        chk("t4_hr01", time_bcd, 16'h0100);
        for (int i = 0; i < 23; i++) press(1'b0);
        chk("t4_hr_wrap", time_bcd, 16'h0000);
        nblank = 0; nlow = 0; nsegbad = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (an === 4'b1111) begin
                nblank++;
                if (seg !== 7'h7F) nsegbad++;
            end
            if (an === 4'b1110 || an === 4'b1101) nlow++;
        end
        chk("t4_blank_cnt", nblank[15:0], 16'd20);
        chk("t4_low_cnt", nlow[15:0], 16'd40);
        chk("t4_blank_seg", nsegbad[15:0], 16'd0);
        chk("t4_frozen", time_bcd, 16'h0000);
        chk("t4_sec_led", {15'd0, sec_led}, 16'd0);

        // Simultaneous presses: mode wins; a held inc counts once
        do_reset();
        step(3);
        btn_mode = 1'b1; btn_inc = 1'b1;
        step(3);
        chk("t5_both_run_mode", {14'd0, mode}, 16'd1);
        chk("t5_both_run_time", time_bcd, 16'h0000);
        btn_mode = 1'b0; btn_inc = 1'b0;
        step(4);
        btn_mode = 1'b1; btn_inc = 1'b1;
        step(3);
        chk("t5_both_hr_mode", {14'd0, mode}, 16'd2);
        chk("t5_both_hr_time", time_bcd, 16'h0000);
        btn_mode = 1'b0; btn_inc = 1'b0;
        step(4);
        btn_inc = 1'b1;
        step(50);
        chk("t5_hold_inc", time_bcd, 16'h0001);
        btn_inc = 1'b0;
        step(4);
        chk("t5_after_hold", time_bcd, 16'h0001);
        press(1'b1);
        chk("t5_back_run", {14'd0, mode}, 16'd0);

        // Reset in SET_MIN while digit 2 is on screen, with a mode edge in flight
        press(1'b1);
        press(1'b1);
        press(1'b0);
        chk("t6_pre_mode", {14'd0, mode}, 16'd2);
        chk("t6_pre_time", time_bcd, 16'h0002);
        wait_an(4'b1011, "t6_wait_d2");
        btn_mode = 1'b1;
        step(1);
        rst = 1'b1; btn_mode = 1'b0;
        step(1);
        chk("t6_rst_mode", {14'd0, mode}, 16'd0);
        chk("t6_rst_time", time_bcd, 16'h0000);
        chk("t6_rst_an", {12'd0, an}, {12'd0, 4'b1110});
        chk("t6_rst_seg", {9'd0, seg}, {9'd0, 7'b1000000});
        chk("t6_rst_dp", {15'd0, dp}, 16'd1);
        rst = 1'b0;
        step(6);
        chk("t6_edge_dropped", {14'd0, mode}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
